// File: rtl/lza_norm_corr.sv
// Post-LZA normalizer: coarse left shift by the anticipated count,
// then a one-position fix-up for the LZA undershoot. Two pipeline stages.
module lza_norm_corr #(
  parameter int C_WIDTH    = 74,
  parameter int C_LZ_WIDTH = 7
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Valid_SI,
  output logic                  Ready_SO,
  input  logic [C_WIDTH-1:0]    Mant_DI,
  input  logic [C_LZ_WIDTH-1:0] LzCnt_DI,
  input  logic                  NoOne_SI,
  output logic                  Valid_SO,
  input  logic                  Ready_SI,
  output logic [C_WIDTH-1:0]    Mant_DO,
  output logic [C_LZ_WIDTH-1:0] Shift_DO,
  output logic                  Corr_SO,
  output logic                  Zero_SO,
  output logic                  LzaErr_SO
);

  localparam logic [C_LZ_WIDTH-1:0] MAX_CNT =
    C_LZ_WIDTH'(C_WIDTH - 1);

  logic                  v1_q;
  logic [C_WIDTH-1:0]    mant1_q;
  logic [C_LZ_WIDTH-1:0] cnt1_q;
  logic                  none1_q;

  logic                  adv2;
  logic                  acc;
  logic                  ld2;
  logic [C_LZ_WIDTH-1:0] cnt_sat;

  logic [C_WIDTH-1:0]    coarse;
  logic                  is_zero;
  logic                  sat;

  logic [C_WIDTH-1:0]    n_mant;
  logic [C_LZ_WIDTH-1:0] n_shift;
  logic                  n_corr;
  logic                  n_zero;
  logic                  n_err;

  // Handshake: stage 2 frees when empty or drained; stage 1 frees
  // when empty or able to move into stage 2.
  assign adv2     = !Valid_SO | Ready_SI;
  assign Ready_SO = !v1_q | adv2;
  assign acc      = Valid_SI & Ready_SO;
  assign ld2      = v1_q & adv2;

  assign cnt_sat = (LzCnt_DI > MAX_CNT) ? MAX_CNT : LzCnt_DI;

  // Stage 1 register: raw magnitude plus the clamped count.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      v1_q    <= 1'b0;
      mant1_q <= '0;
      cnt1_q  <= '0;
      none1_q <= 1'b0;
    end else begin
      if (acc) begin
        v1_q    <= 1'b1;
        mant1_q <= Mant_DI;
        cnt1_q  <= cnt_sat;
        none1_q <= NoOne_SI;
      end else if (adv2) begin
        v1_q    <= 1'b0;
      end
    end
  end

  assign coarse  = mant1_q << cnt1_q;
  assign is_zero = none1_q | ~|mant1_q;
  assign sat     = (cnt1_q == MAX_CNT);

  // Correction select: already normalized, or one extra shift.
  always_comb begin
    n_mant  = coarse;
    n_shift = cnt1_q;
    n_corr  = 1'b0;
    n_zero  = 1'b0;
    n_err   = 1'b0;
    unique case (1'b1)
      is_zero: begin
        n_mant  = '0;
        n_shift = '0;
        n_zero  = 1'b1;
      end
      !is_zero & coarse[C_WIDTH-1]: begin
        n_mant  = coarse;
      end
      !is_zero & !coarse[C_WIDTH-1]: begin
        n_mant = coarse << 1;
        n_err  = !coarse[C_WIDTH-2];
        if (sat) begin
          n_shift = MAX_CNT;
          n_corr  = 1'b0;
        end else begin
          n_shift = cnt1_q + 1'b1;
          n_corr  = 1'b1;
        end
      end
      default: begin
        n_mant = coarse;
      end
    endcase
  end

  // Stage 2 / output register, held while stalled.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      Valid_SO  <= 1'b0;
      Mant_DO   <= '0;
      Shift_DO  <= '0;
      Corr_SO   <= 1'b0;
      Zero_SO   <= 1'b0;
      LzaErr_SO <= 1'b0;
    end else begin
      if (adv2) begin
        Valid_SO <= v1_q;
      end
      if (ld2) begin
        Mant_DO   <= n_mant;
        Shift_DO  <= n_shift;
        Corr_SO   <= n_corr;
        Zero_SO   <= n_zero;
        LzaErr_SO <= n_err;
      end
    end
  end

endmodule

// File: tb/tb_lza_norm_corr.sv
// Directed bench for lza_norm_corr at 8-bit width.
// Hand-computed vectors, stall, flush and ordering checks.
module tb_lza_norm_corr;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_si;
  logic       ready_so;
  logic [7:0] mant_di;
  logic [2:0] lz_di;
  logic       none_si;
  logic       valid_so;
  logic       ready_si;
  logic [7:0] mant_do;
  logic [2:0] shift_do;
  logic       corr_so;
  logic       zero_so;
  logic       err_so;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lza_norm_corr #(
    .C_WIDTH(8),
    .C_LZ_WIDTH(3)
  ) dut (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .Valid_SI(valid_si),
    .Ready_SO(ready_so),
    .Mant_DI(mant_di),
    .LzCnt_DI(lz_di),
    .NoOne_SI(none_si),
    .Valid_SO(valid_so),
    .Ready_SI(ready_si),
    .Mant_DO(mant_do),
    .Shift_DO(shift_do),
    .Corr_SO(corr_so),
    .Zero_SO(zero_so),
    .LzaErr_SO(err_so)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag,
                        input logic [7:0] m,
                        input logic [2:0] lz,
                        input logic       no,
                        input logic [7:0] em,
                        input logic [2:0] es,
                        input logic       ec,
                        input logic       ez,
                        input logic       ee);
    ready_si = 1'b1;
    valid_si = 1'b1;
    mant_di  = m;
    lz_di    = lz;
    none_si  = no;
    tick();
    valid_si = 1'b0;
    chk({tag, "_lat1"}, 32'(valid_so), 32'd0);
    tick();
    chk({tag, "_vld"},   32'(valid_so), 32'd1);
    chk({tag, "_mant"},  32'(mant_do),  32'(em));
    chk({tag, "_shift"}, 32'(shift_do), 32'(es));
    chk({tag, "_corr"},  32'(corr_so),  32'(ec));
    chk({tag, "_zero"},  32'(zero_so),  32'(ez));
    chk({tag, "_err"},   32'(err_so),   32'(ee));
    tick();
    chk({tag, "_drain"}, 32'(valid_so), 32'd0);
  endtask

  logic [7:0] bm [4] = '{8'h13, 8'h13, 8'h01, 8'h40};
  logic [2:0] bl [4] = '{3'd3, 3'd2, 3'd7, 3'd0};
  logic [7:0] em [4] = '{8'h98, 8'h98, 8'h80, 8'h80};
  logic [2:0] es [4] = '{3'd3, 3'd3, 3'd7, 3'd1};
  logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int idx;
    int got;
    logic acc;
    logic [7:0] snap_m;
    logic [2:0] snap_s;
    logic snap_c;

    rst      = 1'b1;
    valid_si = 1'b0;
    ready_si = 1'b0;
    mant_di  = '0;
    lz_di    = '0;
    none_si  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_vld",   32'(valid_so), 32'd0);
    chk("rst_rdy",   32'(ready_so), 32'd1);
    chk("rst_mant",  32'(mant_do),  32'd0);
    chk("rst_shift", 32'(shift_do), 32'd0);
    chk("rst_corr",  32'(corr_so),  32'd0);
    chk("rst_zero",  32'(zero_so),  32'd0);
    chk("rst_err",   32'(err_so),   32'd0);

    single("t1", 8'h13, 3'd3, 1'b0, 8'h98, 3'd3, 1'b0, 1'b0, 1'b0);
    single("t2", 8'h13, 3'd2, 1'b0, 8'h98, 3'd3, 1'b1, 1'b0, 1'b0);
    single("t3", 8'h13, 3'd1, 1'b0, 8'h4C, 3'd2, 1'b1, 1'b0, 1'b1);
    single("t4", 8'h00, 3'd7, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    single("t4b", 8'h00, 3'd3, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    single("t4c", 8'h5A, 3'd1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    single("tmax", 8'h01, 3'd7, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0);
    single("tnorm", 8'h80, 3'd0, 1'b0, 8'h80, 3'd0, 1'b0, 1'b0, 1'b0);
    single("tund0", 8'h40, 3'd0, 1'b0, 8'h80, 3'd1, 1'b1, 1'b0, 1'b0);

    idx      = 0;
    got      = 0;
    snap_m   = '0;
    snap_s   = '0;
    snap_c   = 1'b0;
    valid_si = 1'b1;
    mant_di  = bm[0];
    lz_di    = bl[0];
    none_si  = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      ready_si = (c >= 5);
      #1;
      if (c == 1) chk("t5_rdy_one", 32'(ready_so), 32'd1);
      if (c == 2) begin
        chk("t5_rdy_drop", 32'(ready_so), 32'd0);
        snap_m = mant_do;
        snap_s = shift_do;
        snap_c = corr_so;
      end
      if (c > 2 && c <= 5) begin
        chk("t5_stall_vld",   32'(valid_so), 32'd1);
        chk("t5_stall_mant",  32'(mant_do),  32'(snap_m));
        chk("t5_stall_shift", 32'(shift_do), 32'(snap_s));
        chk("t5_stall_corr",  32'(corr_so),  32'(snap_c));
      end
      acc = valid_si && ready_so;
      if (valid_so && ready_si) begin
        chk("t5_mant",  32'(mant_do),  32'(em[got]));
        chk("t5_shift", 32'(shift_do), 32'(es[got]));
        chk("t5_corr",  32'(corr_so),  32'(ec[got]));
        got++;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) begin
          mant_di = bm[idx];
          lz_di   = bl[idx];
        end else begin
          valid_si = 1'b0;
        end
      end
    end
    chk("t5_count", 32'(got), 32'd4);
    valid_si = 1'b0;
    tick();
    chk("t5_empty", 32'(valid_so), 32'd0);

    ready_si = 1'b0;
    valid_si = 1'b1;
    mant_di  = 8'h13;
    lz_di    = 3'd3;
    tick();
    mant_di  = 8'h01;
    lz_di    = 3'd7;
    tick();
    valid_si = 1'b0;
    chk("t6_full", 32'(ready_so), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_flush_vld", 32'(valid_so), 32'd0);
    chk("t6_flush_rdy", 32'(ready_so), 32'd1);
    ready_si = 1'b1;
    valid_si = 1'b1;
    mant_di  = 8'h40;
    lz_di    = 3'd0;
    tick();
    valid_si = 1'b0;
    chk("t6_lat1", 32'(valid_so), 32'd0);
    tick();
    chk("t6_vld",   32'(valid_so), 32'd1);
    chk("t6_mant",  32'(mant_do),  32'h80);
    chk("t6_shift", 32'(shift_do), 32'd1);
    chk("t6_corr",  32'(corr_so),  32'd1);
    tick();
    chk("t6_ghost", 32'(valid_so), 32'd0);
    tick();
    chk("t6_ghost2", 32'(valid_so), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
